// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv instruction-fetch front end.
package riscv_pkg;

  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory port, redirect input and decode port.
interface riscv_fetch_ctrl_if #(
  parameter int XLEN = 64
);
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst_data;
  logic            inst_fault;
  logic            halted;

  // The fetch controller drives requests and the decode-facing outputs.
  modport master (
    output imem_req_valid, imem_req_addr,
    output inst_valid, inst_pc, inst_data, inst_fault, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  inst_valid, inst_pc, inst_data, inst_fault, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, keeps one memory request in flight,
// holds the returned word for decode and handles redirects, stale responses and faults.
module riscv_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESETVEC = XLEN'(32'h8000_0000)
) (
  input logic                clk,
  input logic                reset,
  riscv_fetch_ctrl_if.master bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "riscv_fetch_ctrl: XLEN must be 32 or 64");
  end

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic [ILEN-1:0] r_data;
  logic            r_fault;

  logic            w_aligned;
  logic            w_req_fire;
  logic [XLEN-1:0] w_pc_inc;

  assign w_aligned  = !is_misaligned(r_pc[1:0]);
  assign w_req_fire = (r_state == REQ) && w_aligned && bus.imem_req_ready;
  assign w_pc_inc   = r_pc + XLEN'(INST_BYTES);

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
      r_pc    <= RESETVEC;
      r_kill  <= 1'b0;
      r_data  <= '0;
      r_fault <= 1'b0;
    end else begin
      unique case (r_state)
        REQ: begin
          if (!w_aligned) begin
            r_state <= HOLD;
            r_fault <= 1'b1;
            r_data  <= '0;
          end else if (w_req_fire) begin
            r_state <= WAIT;
            if (bus.redirect_valid) begin
              r_pc   <= bus.redirect_pc;
              r_kill <= 1'b1;
            end
          end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
          end
        end

        WAIT: begin
          // A response that crosses a redirect, or arrives with kill set, is stale.
          if (bus.imem_rsp_valid) begin
            if (bus.redirect_valid) begin
              r_pc    <= bus.redirect_pc;
              r_kill  <= 1'b0;
              r_state <= REQ;
            end else if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_state <= HOLD;
              r_fault <= bus.imem_rsp_err;
              r_data  <= bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
            end
          end else if (bus.redirect_valid) begin
            r_pc   <= bus.redirect_pc;
            r_kill <= 1'b1;
          end
        end

        HOLD: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= REQ;
          end else if (bus.inst_ready) begin
            if (r_fault) begin
              r_state <= HALT;
            end else begin
              r_pc    <= w_pc_inc;
              r_state <= REQ;
            end
          end
        end

        HALT: begin
          if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_pc;
            r_state <= REQ;
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only; reset masks them while it is held.
  assign bus.imem_req_valid = !reset && (r_state == REQ) && w_aligned;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = !reset && (r_state == HOLD);
  assign bus.inst_pc        = r_pc;
  assign bus.inst_data      = r_data;
  assign bus.inst_fault     = r_fault;
  assign bus.halted         = !reset && (r_state == HALT);

  a_rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) bus.imem_rsp_valid |-> (r_state == WAIT)
  );

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Scoreboard bench for riscv_fetch_ctrl: random memory/decode/redirect stimulus
// against an architectural model of the expected instruction stream.
module tb_riscv_fetch_ctrl;
  import riscv_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESETVEC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_fetch_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_fetch_ctrl #(.XLEN(XLEN), .RESETVEC(RESETVEC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  bit   exp_halted = 1'b0;

  int          mem_ready_pct = 100;
  int          mem_lat_max   = 0;
  int          dec_ready_pct = 100;
  int          redir_pct     = 0;
  bit          dir_redir     = 1'b0;
  logic [31:0] dir_redir_pc  = '0;
  bit          chk_lat       = 1'b0;

  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  int idle = 0;
  int last_req = -1;
  int last_iv = -1;
  bit prev_req = 1'b0;
  bit prev_iv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory contents are a fixed hash of the address; two addresses return a bus error.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return (a == 32'h8000_0010) || (a == 32'h8000_0040);
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.fault = (a[1:0] != 2'b00) || is_err(a);
    e.data  = e.fault ? 32'h0 : mem_word(a);
    return e;
  endfunction

  function automatic logic [31:0] rand_target();
    int unsigned sel;
    logic [31:0] base;
    sel  = $urandom_range(99);
    base = 32'h8000_0000 + ($urandom_range(63) << 2);
    if (sel < 60) return base;
    if (sel < 72) return base | 32'($urandom_range(3, 1));
    if (sel < 84) return sel[0] ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
    return 32'($urandom_range(15) << 2);
  endfunction

  // Memory responder: one request at a time, random ready and latency.
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      bus.imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(pend_addr);
          bus.imem_rsp_err   = is_err(pend_addr);
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      bus.imem_req_ready = ($urandom_range(99) < mem_ready_pct);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = bus.imem_req_addr;
        pend_cnt  = int'($urandom_range(mem_lat_max, 0));
      end
    end
  end

  // Decode/redirect driver; pushes the next expected instruction whenever it
  // issues a redirect or an accept.
  initial begin
    exp_t e;
    bit   blocked;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      if (!rst) begin
        bus.inst_ready = ($urandom_range(99) < dec_ready_pct);
        blocked = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          blocked = (e.pc[1:0] != 2'b00) && !bus.inst_valid;
        end
        if (dir_redir) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = dir_redir_pc;
          dir_redir          = 1'b0;
        end else if (!blocked && redir_pct > 0 &&
                     (($urandom_range(99) < redir_pct) || (exp_halted && $urandom_range(3) == 0))) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = rand_target();
        end
        if (bus.redirect_valid) begin
          exp_q.delete();
          exp_q.push_back(make_exp(bus.redirect_pc));
          exp_halted = 1'b0;
        end else if (bus.inst_valid && bus.inst_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.fault) exp_halted = 1'b1;
          else         exp_q.push_back(make_exp(e.pc + 32'd4));
        end
      end
    end
  end

  // Monitor: compares every presented instruction against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_halted", bus.halted, 0);
        prev_req = 1'b0;
        prev_iv  = 1'b0;
        last_iv  = -1;
        idle     = 0;
      end else begin
        check("halted", bus.halted, exp_halted);
        if (exp_halted) check("req_in_halt", bus.imem_req_valid, 0);
        if (bus.imem_req_valid) begin
          check("req_single_outstanding", pend, 0);
          check("req_addr_aligned", bus.imem_req_addr[1:0], 0);
        end
        if (bus.inst_valid) begin
          idle = 0;
          check("req_while_hold", bus.imem_req_valid, 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_inst: pc %0h presented, nothing expected (cycle %0d)", bus.inst_pc, cyc);
          end else begin
            e = exp_q[0];
            check("inst_pc", bus.inst_pc, e.pc);
            check("inst_data", bus.inst_data, e.data);
            check("inst_fault", bus.inst_fault, e.fault);
          end
        end else if (bus.halted) begin
          idle = 0;
        end else begin
          idle++;
          if (idle > 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL progress_timeout: no instruction for 60 cycles (cycle %0d)", cyc);
            idle = 0;
          end
        end
        if (chk_lat) begin
          if (bus.imem_req_valid && !prev_req) last_req = cyc;
          if (bus.inst_valid && !prev_iv) begin
            check("req_to_inst_latency", 64'(cyc - last_req), 2);
            if (last_iv >= 0) check("inst_spacing", 64'(cyc - last_iv), 3);
            last_iv = cyc;
          end
        end
        prev_req = bus.imem_req_valid;
        prev_iv  = bus.inst_valid;
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(make_exp(RESETVEC));
    exp_halted = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    @(negedge clk);
    #1;
    dir_redir_pc = target;
    dir_redir    = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.halted) break;
    end
    check("halt_reached", bus.halted, 1);
  endtask

  task automatic set_knobs(input int mrdy, input int lat, input int drdy, input int rdr);
    mem_ready_pct = mrdy;
    mem_lat_max   = lat;
    dec_ready_pct = drdy;
    redir_pct     = rdr;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    // Straight-line fetch from the reset vector until the bus error at 8000_0010.
    set_knobs(100, 0, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", bus.imem_req_addr, RESETVEC);
    chk_lat = 1'b1;
    release_reset();
    wait_halted(60);
    check("halt_pc_err", bus.inst_pc, 32'h8000_0010);
    chk_lat = 1'b0;
    repeat (4) @(negedge clk);

    // Decode stall in HOLD, then run on into the second error address.
    dec_ready_pct = 0;
    do_redirect(32'h8000_0020);
    repeat (10) @(negedge clk);
    dec_ready_pct = 100;
    wait_halted(80);

    // Misaligned target faults without a request; then resume across the wrap.
    do_redirect(32'h8000_0102);
    wait_halted(20);
    check("halt_pc_misaligned", bus.inst_pc, 32'h8000_0102);
    do_redirect(32'hFFFF_FFF8);
    repeat (20) @(negedge clk);

    // Random traffic in two flavours.
    set_knobs(60, 3, 60, 12);
    repeat (1500) @(negedge clk);
    set_knobs(80, 2, 80, 30);
    repeat (1500) @(negedge clk);

    // Park in HALT, reset mid-run and re-check the reset timing.
    set_knobs(80, 2, 80, 0);
    do_redirect(32'h8000_0103);
    wait_halted(100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    set_knobs(100, 0, 100, 0);
    chk_lat = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    wait_halted(60);
    chk_lat = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_ctrl.md
Name: riscv_fetch_ctrl

Overview:
Instruction-fetch sequencer for the riscv core. Owns the program counter and issues single-outstanding requests on a valid/ready instruction-memory port. Holds each returned instruction until decode accepts it. Handles redirects (branch/jump/trap), discards stale responses, and reports misaligned-target and bus-error faults. The core instantiates it in place of its bare pc register.

Parameters:
XLEN, 9'd64, datapath/address width; only 32 or 64 legal (elaboration $fatal otherwise)
RESETVEC, {{(XLEN-32){1'b0}},32'h8000_0000}, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response valid (always accepted)
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  bus error on this response
redirect_valid  in  1  replace pc with redirect_pc
redirect_pc  in  XLEN  redirect target
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst_pc  out  XLEN  address of presented instruction
inst_data  out  32  instruction word (0 on fault)
inst_fault  out  1  1 = misaligned target or bus error
halted  out  1  fetch stopped after fault, waiting for redirect

Behaviour:
- Single clock. reset sampled only on posedge clk.
- Reset: pc=RESETVEC, state=REQ, kill=0, data/fault regs=0.
- Outputs while reset is high: all valids 0, halted 0.
- States: REQ, WAIT, HOLD, HALT. Outputs are registered state decodes, with no combinational path from inputs:
  - imem_req_valid = (state==REQ && pc[1:0]==0)
  - inst_valid = (state==HOLD)
  - halted = (state==HALT)
  - imem_req_addr = inst_pc = pc
- REQ, aligned pc:
  - req handshake, no redirect -> WAIT.
  - req handshake plus redirect -> pc=redirect_pc, kill=1, WAIT.
  - no handshake plus redirect -> pc=redirect_pc, stay REQ. The request is retargeted; memory must not assume address stability across a redirect.
- REQ, misaligned pc: no request issued. Next cycle -> HOLD with fault=1, data=0.
- WAIT:
  - rsp_valid with kill=0 -> latch data/err into HOLD.
  - rsp_valid with kill=1 -> drop response, kill=0, REQ.
  - redirect without rsp -> pc=redirect_pc, kill=1, stay WAIT.
  - redirect plus rsp same cycle -> drop response, pc=redirect_pc, kill=0, REQ.
- HOLD:
  - redirect has priority -> pc=redirect_pc, REQ. The held instruction is discarded even if inst_ready=1; decode must ignore its own handshake in the cycle it raises redirect.
  - inst_ready with fault=0 -> pc=pc+4, REQ.
  - inst_ready with fault=1 -> HALT, pc unchanged.
- HALT: only redirect exits -> pc=redirect_pc, REQ. Other inputs ignored.
- Arithmetic: pc+4 is XLEN-bit modulo 2^XLEN; all-ones-minus-3 wraps to 0. No carry out.
- At most one outstanding memory request ever. Responses arriving in REQ/HOLD/HALT are protocol errors; assertion only, ignored by RTL.
- Latency: imem_req_valid=1 in the first cycle after reset deasserts. With ready=1 and the response one cycle later, inst_valid=1 two cycles after the request cycle. Best throughput is 1 instruction per 3 cycles.
- Reset mid-operation: returns to the reset state next edge. kill is cleared, so a late response from before reset is a protocol error the memory side must not produce.

Decomposition:
- riscv_pkg: fetch_state_t enum {REQ,WAIT,HOLD,HALT}, ILEN=32, INST_BYTES=4, NOP encoding 32'h0000_0013 for bench use.
- No sub-module. FSM plus pc/kill/data registers live in riscv_fetch_ctrl.
- The core's pc register is removed; next-pc logic flows through redirect.

Test Plan:
1. Reset 3 cycles, memory ready=1, rsp next cycle with data=32'h0000_0013, inst_ready=1 -> requests at 8000_0000, 8000_0004, 8000_0008; inst_pc matches; inst_valid every 3rd cycle.
2. Decode stalls (inst_ready=0 for 5 cycles) in HOLD -> inst_valid, inst_data, inst_pc stable; no new imem_req_valid until accept.
3. Redirect to 8000_0100 while WAIT, rsp 2 cycles later with 32'hDEAD_BEEF -> response dropped, never presented; next request addr 8000_0100.
4. Redirect plus rsp_valid same cycle in WAIT -> response dropped, REQ next cycle with the new pc, kill=0.
5. Redirect to 8000_0102 -> no imem_req_valid. Next cycle inst_valid=1, inst_fault=1, inst_data=0, inst_pc=8000_0102. After accept, halted=1. Redirect 8000_0000 resumes fetch.
6. rsp_err=1 at 8000_0010 -> inst_fault=1 presented, then HALT. XLEN=32 build: pc=FFFF_FFFC accepted -> next request addr 0000_0000.
